fc_layer_sequencer: RTL and testbench
=====================================

Name: fc_layer_sequencer

Overview:
- Steps a chain of fully-connected layers through one shared fc_runner datapath.
- Per layer: fetches a descriptor from a small descriptor memory, validates it, and drives the runner's cfg_* inputs with ping-pong activation buffer bases.
- Pulses the runner's start, waits for its done, then advances.
- Sits between the top-level network controller and fc_runner; also exports the layer index used to select weight/quant tables.

Parameters:
- DIM_W, 16, channel count width (matches fc_runner).
- ADDR_W, 32, activation address width.
- MAX_IN_CH, 1024, largest legal in_c (fc_runner buffer depth).
- MAX_LAYERS, 16, descriptor table depth; layer index width is clog2(MAX_LAYERS).
- WDOG_CYCLES, 1048576, maximum cycles allowed in RUN per layer.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin sequence; sampled in IDLE only.
- abort  in  1  request stop at the next layer boundary.
- cfg_buf_a  in  ADDR_W  activation buffer A base; layer 0 input.
- cfg_buf_b  in  ADDR_W  activation buffer B base.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at sequence end (normal or aborted).
- error  out  1  sticky fault flag.
- err_code  out  2  1 = bad descriptor, 2 = no last flag found, 3 = watchdog timeout.
- aborted  out  1  sticky; set when the sequence ended by abort.
- desc_rd_en  out  1  descriptor read strobe.
- desc_rd_addr  out  clog2(MAX_LAYERS)  descriptor index.
- desc_rd_data  in  2*DIM_W+1  descriptor: [DIM_W-1:0] = in_c, [2*DIM_W-1:DIM_W] = out_c, [2*DIM_W] = last.
- run_start  out  1  start to fc_runner.
- run_busy  in  1  fc_runner busy.
- run_done  in  1  fc_runner done pulse.
- run_in_c, run_out_c  out  DIM_W  runner channel config.
- run_in_base, run_out_base  out  ADDR_W  runner buffer bases.
- layer_idx  out  clog2(MAX_LAYERS)  current layer.
- final_out_base  out  ADDR_W  output base of the last completed layer.

Behaviour:
- Reset: state = IDLE; every output and internal register = 0, including the sticky flags and the pending-abort flag.
- States and transitions:
  - IDLE: on start, clear error, err_code and aborted; capture cfg_buf_a and cfg_buf_b; layer_idx = 0; clear the pending-abort flag; go to FETCH.
  - FETCH: 1 cycle; desc_rd_en = 1, desc_rd_addr = layer_idx.
  - WAIT_DESC: read latency is 1 cycle; register desc_rd_data into in_c, out_c and last.
  - CHECK: 1 cycle.
    - in_c == 0, out_c == 0, or in_c > MAX_IN_CH -> ERR, code 1.
    - Otherwise set run_in_c and run_out_c. Even layer: run_in_base = buf_a, run_out_base = buf_b. Odd layer: swapped.
  - START: run_start = !run_busy. Go to RUN in the cycle run_start is high. Bases and counts stay stable from CHECK through the end of RUN.
  - RUN: wait for run_done. Watchdog counts cycles in RUN, cleared on entry; reaching WDOG_CYCLES -> ERR, code 3.
  - NEXT: final_out_base = run_out_base.
    - pending abort -> DONE with aborted = 1.
    - else last -> DONE.
    - else layer_idx == MAX_LAYERS-1 -> ERR, code 2.
    - else layer_idx + 1 -> FETCH.
  - DONE: done = 1 for 1 cycle, then IDLE.
  - ERR: error = 1 with err_code set; done = 1 for 1 cycle; then IDLE. error and err_code hold until the next accepted start.
- abort in any non-IDLE state sets the pending-abort flag. The current runner layer is never interrupted, since fc_runner has no abort. A pending abort is honoured only at NEXT; an ERR path takes priority over it. abort in IDLE is ignored.
- start while busy: ignored. run_done outside RUN: ignored.
- Combinational outputs are desc_rd_en and run_start only; everything else is registered.
- Per-layer overhead beyond runner time: 5 cycles (FETCH, WAIT_DESC, CHECK, START, NEXT), with START minimal when run_busy = 0.
- Reset mid-sequence: immediate return to IDLE with all outputs 0; run_start drops in the same cycle.

Test Plan:
- 3 layers, descriptors (8,4,0), (4,2,0), (2,10,1); buf_a = 0x100, buf_b = 0x200; runner model returns done 20 cycles after start.
  -> run_in_base/run_out_base = 0x100/0x200, then 0x200/0x100, then 0x100/0x200.
  -> 3 run_start pulses, one done pulse, final_out_base = 0x200, error = 0.
- Layer 1 descriptor in_c = 1025 -> err_code = 1, error = 1, done pulse, only 1 run_start issued.
- MAX_LAYERS = 4 and no last flag set -> after 4 layers, err_code = 2.
- WDOG_CYCLES = 50, runner never asserts done -> ERR with code 3 at cycle 50 of RUN; busy low on the next cycle.
- abort pulsed mid layer 0 of 3 -> layer 0 completes, no further run_start, aborted = 1, done pulse, final_out_base = 0x200.
- run_busy held high for 7 cycles entering START -> run_start is first asserted in the cycle run_busy falls. Also check: start asserted while busy is ignored, and rst mid-RUN returns busy to 0 on the next cycle.

Source files
------------

// File: rtl/fc_layer_sequencer_if.sv
// Descriptor-memory read port and fc_runner control/config bundle for fc_layer_sequencer.
interface fc_layer_sequencer_if #(
   parameter int unsigned DIM_W  = 16,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned IDX_W  = 4
);
   logic                desc_rd_en;
   logic [IDX_W-1:0]    desc_rd_addr;
   logic [2*DIM_W:0]    desc_rd_data;

   logic                run_start;
   logic                run_busy;
   logic                run_done;
   logic [DIM_W-1:0]    run_in_c;
   logic [DIM_W-1:0]    run_out_c;
   logic [ADDR_W-1:0]   run_in_base;
   logic [ADDR_W-1:0]   run_out_base;

   // Sequencer side
   modport master (
      output desc_rd_en, desc_rd_addr,
      input  desc_rd_data,
      output run_start, run_in_c, run_out_c, run_in_base, run_out_base,
      input  run_busy, run_done
   );

   // Descriptor memory / fc_runner side
   modport slave (
      input  desc_rd_en, desc_rd_addr,
      output desc_rd_data,
      input  run_start, run_in_c, run_out_c, run_in_base, run_out_base,
      output run_busy, run_done
   );
endinterface

// File: rtl/fc_layer_sequencer.sv
// Walks a descriptor table of fully-connected layers, configuring and starting one shared
// fc_runner per layer with ping-pong activation buffers, until a last flag, abort or fault.
module fc_layer_sequencer #(
   parameter int unsigned  DIM_W       = 16,
   parameter int unsigned  ADDR_W      = 32,
   parameter int unsigned  MAX_IN_CH   = 1024,
   parameter int unsigned  MAX_LAYERS  = 16,
   parameter int unsigned  WDOG_CYCLES = 1048576,
   localparam int unsigned IDX_W       = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [ADDR_W-1:0]   cfg_buf_a,
   input  logic [ADDR_W-1:0]   cfg_buf_b,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [1:0]          err_code,
   output logic                aborted,
   output logic [IDX_W-1:0]    layer_idx,
   output logic [ADDR_W-1:0]   final_out_base,
   fc_layer_sequencer_if.master bus
);

   localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

   localparam logic [1:0] ERR_BAD_DESC = 2'd1;
   localparam logic [1:0] ERR_NO_LAST  = 2'd2;
   localparam logic [1:0] ERR_WDOG     = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_DESC,
      S_CHECK,
      S_START,
      S_RUN,
      S_NEXT,
      S_DONE,
      S_ERR
   } state_e;

   state_e              state_q, state_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic [1:0]          err_code_q, err_code_d;
   logic                aborted_q, aborted_d;
   logic                abort_pend_q, abort_pend_d;
   logic [IDX_W-1:0]    layer_idx_q, layer_idx_d;
   logic [ADDR_W-1:0]   buf_a_q, buf_a_d;
   logic [ADDR_W-1:0]   buf_b_q, buf_b_d;
   logic [DIM_W-1:0]    in_c_q, in_c_d;
   logic [DIM_W-1:0]    out_c_q, out_c_d;
   logic                last_q, last_d;
   logic [DIM_W-1:0]    run_in_c_q, run_in_c_d;
   logic [DIM_W-1:0]    run_out_c_q, run_out_c_d;
   logic [ADDR_W-1:0]   run_in_base_q, run_in_base_d;
   logic [ADDR_W-1:0]   run_out_base_q, run_out_base_d;
   logic [ADDR_W-1:0]   final_out_base_q, final_out_base_d;
   logic [WDOG_W-1:0]   wdog_q, wdog_d;

   logic                run_start_c;
   logic                desc_bad_c;

   // Strobes are gated by rst so they drop in the same cycle a reset arrives
   assign run_start_c = (state_q == S_START) && !bus.run_busy && !rst;
   assign desc_bad_c  = (in_c_q == '0) || (out_c_q == '0) || (32'(in_c_q) > MAX_IN_CH);

   assign bus.desc_rd_en   = (state_q == S_FETCH) && !rst;
   assign bus.desc_rd_addr = layer_idx_q;
   assign bus.run_start    = run_start_c;
   assign bus.run_in_c     = run_in_c_q;
   assign bus.run_out_c    = run_out_c_q;
   assign bus.run_in_base  = run_in_base_q;
   assign bus.run_out_base = run_out_base_q;

   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = error_q;
   assign err_code       = err_code_q;
   assign aborted        = aborted_q;
   assign layer_idx      = layer_idx_q;
   assign final_out_base = final_out_base_q;

   // Next-state and registered-output logic
   always_comb begin
      state_d          = state_q;
      error_d          = error_q;
      err_code_d       = err_code_q;
      aborted_d        = aborted_q;
      abort_pend_d     = abort_pend_q;
      layer_idx_d      = layer_idx_q;
      buf_a_d          = buf_a_q;
      buf_b_d          = buf_b_q;
      in_c_d           = in_c_q;
      out_c_d          = out_c_q;
      last_d           = last_q;
      run_in_c_d       = run_in_c_q;
      run_out_c_d      = run_out_c_q;
      run_in_base_d    = run_in_base_q;
      run_out_base_d   = run_out_base_q;
      final_out_base_d = final_out_base_q;
      wdog_d           = wdog_q;

      if ((state_q != S_IDLE) && abort) begin
         abort_pend_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               error_d      = 1'b0;
               err_code_d   = 2'd0;
               aborted_d    = 1'b0;
               abort_pend_d = 1'b0;
               buf_a_d      = cfg_buf_a;
               buf_b_d      = cfg_buf_b;
               layer_idx_d  = '0;
               state_d      = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_WAIT_DESC;
         end
         S_WAIT_DESC: begin
            in_c_d  = bus.desc_rd_data[DIM_W-1:0];
            out_c_d = bus.desc_rd_data[2*DIM_W-1:DIM_W];
            last_d  = bus.desc_rd_data[2*DIM_W];
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (desc_bad_c) begin
               err_code_d = ERR_BAD_DESC;
               state_d    = S_ERR;
            end else begin
               run_in_c_d  = in_c_q;
               run_out_c_d = out_c_q;
               // Odd layers read what the previous layer wrote
               if (layer_idx_q[0]) begin
                  run_in_base_d  = buf_b_q;
                  run_out_base_d = buf_a_q;
               end else begin
                  run_in_base_d  = buf_a_q;
                  run_out_base_d = buf_b_q;
               end
               state_d = S_START;
            end
         end
         S_START: begin
            wdog_d = '0;
            if (run_start_c) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.run_done) begin
               state_d = S_NEXT;
            end else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
               err_code_d = ERR_WDOG;
               state_d    = S_ERR;
            end else begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
         end
         S_NEXT: begin
            final_out_base_d = run_out_base_q;
            if (abort_pend_q || abort) begin
               aborted_d = 1'b1;
               state_d   = S_DONE;
            end else if (last_q) begin
               state_d = S_DONE;
            end else if (layer_idx_q == IDX_W'(MAX_LAYERS - 1)) begin
               err_code_d = ERR_NO_LAST;
               state_d    = S_ERR;
            end else begin
               layer_idx_d = layer_idx_q + IDX_W'(1);
               state_d     = S_FETCH;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_ERR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d == S_ERR) begin
         error_d = 1'b1;
      end
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE) || (state_d == S_ERR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         error_q          <= 1'b0;
         err_code_q       <= 2'd0;
         aborted_q        <= 1'b0;
         abort_pend_q     <= 1'b0;
         layer_idx_q      <= '0;
         buf_a_q          <= '0;
         buf_b_q          <= '0;
         in_c_q           <= '0;
         out_c_q          <= '0;
         last_q           <= 1'b0;
         run_in_c_q       <= '0;
         run_out_c_q      <= '0;
         run_in_base_q    <= '0;
         run_out_base_q   <= '0;
         final_out_base_q <= '0;
         wdog_q           <= '0;
      end else begin
         state_q          <= state_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         error_q          <= error_d;
         err_code_q       <= err_code_d;
         aborted_q        <= aborted_d;
         abort_pend_q     <= abort_pend_d;
         layer_idx_q      <= layer_idx_d;
         buf_a_q          <= buf_a_d;
         buf_b_q          <= buf_b_d;
         in_c_q           <= in_c_d;
         out_c_q          <= out_c_d;
         last_q           <= last_d;
         run_in_c_q       <= run_in_c_d;
         run_out_c_q      <= run_out_c_d;
         run_in_base_q    <= run_in_base_d;
         run_out_base_q   <= run_out_base_d;
         final_out_base_q <= final_out_base_d;
         wdog_q           <= wdog_d;
      end
   end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Randomized and directed bench for fc_layer_sequencer against a per-layer reference model.
module tb_fc_layer_sequencer;

   localparam int unsigned DIM_W      = 16;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned MAX_IN_CH  = 1024;
   localparam int unsigned MAX_LAYERS = 4;
   localparam int unsigned WDOG       = 50;
   localparam int unsigned IDX_W      = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               abort;
   logic [ADDR_W-1:0]  cfg_buf_a;
   logic [ADDR_W-1:0]  cfg_buf_b;
   logic               busy;
   logic               done;
   logic               error;
   logic [1:0]         err_code;
   logic               aborted;
   logic [IDX_W-1:0]   layer_idx;
   logic [ADDR_W-1:0]  final_out_base;

   fc_layer_sequencer_if #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

   fc_layer_sequencer #(
      .DIM_W(DIM_W), .ADDR_W(ADDR_W), .MAX_IN_CH(MAX_IN_CH),
      .MAX_LAYERS(MAX_LAYERS), .WDOG_CYCLES(WDOG)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_buf_a(cfg_buf_a), .cfg_buf_b(cfg_buf_b),
      .busy(busy), .done(done), .error(error), .err_code(err_code),
      .aborted(aborted), .layer_idx(layer_idx), .final_out_base(final_out_base),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Descriptor memory with one-cycle read latency
   logic [2*DIM_W:0] mem [MAX_LAYERS];
   always @(posedge clk) begin
      if (bus.desc_rd_en) bus.desc_rd_data <= mem[bus.desc_rd_addr];
   end

   // Runner model: logs each start's config and returns done run_lat cycles later
   int  run_lat = 20;
   bit  run_hang = 1'b0;
   int  rcnt = 0;
   bit  ractive = 1'b0;
   logic [ADDR_W-1:0] lg_in_base[$];
   logic [ADDR_W-1:0] lg_out_base[$];
   logic [DIM_W-1:0]  lg_in_c[$];
   logic [DIM_W-1:0]  lg_out_c[$];
   int  done_cnt = 0;

   always @(posedge clk) begin
      bus.run_done <= 1'b0;
      if (bus.run_start === 1'b1) begin
         lg_in_base.push_back(bus.run_in_base);
         lg_out_base.push_back(bus.run_out_base);
         lg_in_c.push_back(bus.run_in_c);
         lg_out_c.push_back(bus.run_out_c);
         rcnt    <= run_lat;
         ractive <= 1'b1;
      end else if (ractive && !run_hang) begin
         if (rcnt <= 1) begin
            bus.run_done <= 1'b1;
            ractive      <= 1'b0;
         end else begin
            rcnt <= rcnt - 1;
         end
      end
   end

   always @(posedge clk) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   // Reference model: per-layer walk over the descriptor table
   logic [ADDR_W-1:0] ex_in_base[$];
   logic [ADDR_W-1:0] ex_out_base[$];
   logic [DIM_W-1:0]  ex_in_c[$];
   logic [DIM_W-1:0]  ex_out_c[$];
   int                ex_code;
   bit                ex_ab;
   logic [ADDR_W-1:0] ex_fob = '0;
   int                ex_idx;

   task automatic model_seq(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                            input int abort_layer);
      logic [DIM_W-1:0] ic, oc;
      bit lst;
      ex_in_base.delete(); ex_out_base.delete(); ex_in_c.delete(); ex_out_c.delete();
      ex_code = 0; ex_ab = 1'b0; ex_idx = 0;
      for (int l = 0; l < int'(MAX_LAYERS); l++) begin
         ic  = mem[l][DIM_W-1:0];
         oc  = mem[l][2*DIM_W-1:DIM_W];
         lst = mem[l][2*DIM_W];
         ex_idx = l;
         if (ic == 0 || oc == 0 || int'(ic) > int'(MAX_IN_CH)) begin
            ex_code = 1;
            break;
         end
         ex_in_base.push_back((l % 2 == 0) ? a : b);
         ex_out_base.push_back((l % 2 == 0) ? b : a);
         ex_in_c.push_back(ic);
         ex_out_c.push_back(oc);
         ex_fob = (l % 2 == 0) ? b : a;
         if (l == abort_layer) begin
            ex_ab = 1'b1;
            break;
         end
         if (lst) break;
         if (l == int'(MAX_LAYERS) - 1) ex_code = 2;
      end
   endtask

   // Observed results from one sequence
   int obs_done;
   bit obs_timeout;

   task automatic clear_logs();
      lg_in_base.delete(); lg_out_base.delete(); lg_in_c.delete(); lg_out_c.delete();
   endtask

   task automatic run_seq(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                          input int lat, input int abort_after);
      int d0, n, since;
      clear_logs();
      run_lat = lat; run_hang = 1'b0;
      d0 = done_cnt;
      @(negedge clk); cfg_buf_a = a; cfg_buf_b = b; start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0; since = -1;
      while (done_cnt == d0 && n < 2000) begin
         @(negedge clk);
         n++;
         if (since >= 0) since++;
         else if (lg_in_base.size() > 0) since = 0;
         abort = (abort_after >= 0 && since == abort_after);
      end
      abort = 1'b0;
      obs_timeout = (n >= 2000);
      repeat (3) @(negedge clk);
      obs_done = done_cnt - d0;
   endtask

   task automatic load_spec_three();
      mem[0] = {1'b0, 16'd4,  16'd8};
      mem[1] = {1'b0, 16'd2,  16'd4};
      mem[2] = {1'b1, 16'd10, 16'd2};
      mem[3] = {1'b0, 16'd0,  16'd0};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, error, err_code, aborted, layer_idx, final_out_base} !== '0)
         $display("FAIL reset_status: got %h want 0",
                  {busy, done, error, err_code, aborted, layer_idx, final_out_base});
      else n_pass++;
      n_checks++;
      if ({bus.run_start, bus.desc_rd_en, bus.desc_rd_addr, bus.run_in_c, bus.run_out_c,
           bus.run_in_base, bus.run_out_base} !== '0)
         $display("FAIL reset_bus: got %h want 0",
                  {bus.run_start, bus.desc_rd_en, bus.desc_rd_addr, bus.run_in_c,
                   bus.run_out_c, bus.run_in_base, bus.run_out_base});
      else n_pass++;
      ex_fob = '0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_three_layers();
      load_spec_three();
      model_seq(32'h100, 32'h200, -1);
      run_seq(32'h100, 32'h200, 20, -1);
      n_checks++;
      if (lg_in_base.size() != 3) $display("FAIL three_starts: got %0d want 3", lg_in_base.size());
      else n_pass++;
      for (int i = 0; i < ex_in_base.size() && i < lg_in_base.size(); i++) begin
         n_checks++;
         if ({lg_in_base[i], lg_out_base[i], lg_in_c[i], lg_out_c[i]} !==
             {ex_in_base[i], ex_out_base[i], ex_in_c[i], ex_out_c[i]})
            $display("FAIL three_cfg%0d: got %h/%h/%0d/%0d want %h/%h/%0d/%0d", i,
                     lg_in_base[i], lg_out_base[i], lg_in_c[i], lg_out_c[i],
                     ex_in_base[i], ex_out_base[i], ex_in_c[i], ex_out_c[i]);
         else n_pass++;
      end
      n_checks++;
      if (obs_done != 1 || obs_timeout) $display("FAIL three_done: got %0d pulses timeout=%0d want 1", obs_done, obs_timeout);
      else n_pass++;
      n_checks++;
      if ({error, err_code, aborted, busy} !== 5'b0) $display("FAIL three_flags: got %b want 00000", {error, err_code, aborted, busy});
      else n_pass++;
      n_checks++;
      if (final_out_base !== 32'h200) $display("FAIL three_fob: got %h want 00000200", final_out_base);
      else n_pass++;
   endtask

   task automatic test_bad_desc();
      load_spec_three();
      mem[1] = {1'b0, 16'd2, 16'd1025};
      model_seq(32'h100, 32'h200, -1);
      run_seq(32'h100, 32'h200, 20, -1);
      n_checks++;
      if (lg_in_base.size() != 1) $display("FAIL bad_starts: got %0d want 1", lg_in_base.size());
      else n_pass++;
      n_checks++;
      if ({error, err_code} !== 3'b101 || obs_done != 1) $display("FAIL bad_err: got err=%b code=%0d done=%0d want 1/1/1", error, err_code, obs_done);
      else n_pass++;
      n_checks++;
      if (layer_idx !== IDX_W'(ex_idx) || final_out_base !== ex_fob) $display("FAIL bad_idx: got %0d/%h want %0d/%h", layer_idx, final_out_base, ex_idx, ex_fob);
      else n_pass++;
   endtask

   task automatic test_no_last();
      for (int l = 0; l < int'(MAX_LAYERS); l++) mem[l] = {1'b0, 16'(l + 3), 16'(l + 5)};
      model_seq(32'hA000, 32'hB000, -1);
      run_seq(32'hA000, 32'hB000, 6, -1);
      n_checks++;
      if (lg_in_base.size() != 4) $display("FAIL nolast_starts: got %0d want 4", lg_in_base.size());
      else n_pass++;
      n_checks++;
      if ({error, err_code, aborted} !== {1'b1, 2'd2, 1'b0} || obs_done != 1) $display("FAIL nolast_err: got err=%b code=%0d ab=%b done=%0d want 1/2/0/1", error, err_code, aborted, obs_done);
      else n_pass++;
      n_checks++;
      if (final_out_base !== ex_fob || layer_idx !== 2'd3) $display("FAIL nolast_fob: got %h/%0d want %h/3", final_out_base, layer_idx, ex_fob);
      else n_pass++;
   endtask

   task automatic test_watchdog();
      int n;
      load_spec_three();
      clear_logs();
      run_hang = 1'b1;
      @(negedge clk); cfg_buf_a = 32'h100; cfg_buf_b = 32'h200; start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (bus.run_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      n = 0;
      while (error !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      n_checks++;
      if (n != int'(WDOG) + 1) $display("FAIL wdog_time: got error %0d cycles after start cycle want %0d", n, WDOG + 1);
      else n_pass++;
      n_checks++;
      if ({done, err_code} !== 3'b111) $display("FAIL wdog_code: got done=%b code=%0d want 1/3", done, err_code);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({busy, error, err_code} !== 4'b0111 || final_out_base !== ex_fob) $display("FAIL wdog_after: got busy=%b err=%b code=%0d fob=%h want 0/1/3/%h", busy, error, err_code, final_out_base, ex_fob);
      else n_pass++;
      run_hang = 1'b0;
      repeat (25) @(negedge clk);
   endtask

   task automatic test_abort();
      load_spec_three();
      model_seq(32'h100, 32'h200, 0);
      run_seq(32'h100, 32'h200, 20, 5);
      n_checks++;
      if (lg_in_base.size() != 1) $display("FAIL abort_starts: got %0d want 1", lg_in_base.size());
      else n_pass++;
      n_checks++;
      if ({aborted, error, obs_done} !== {1'b1, 1'b0, 32'd1} || final_out_base !== 32'h200) $display("FAIL abort_flags: got ab=%b err=%b done=%0d fob=%h want 1/0/1/00000200", aborted, error, obs_done, final_out_base);
      else n_pass++;
   endtask

   task automatic test_busy_start();
      int d0, n;
      bit early;
      load_spec_three();
      model_seq(32'h100, 32'h200, -1);
      clear_logs();
      run_lat = 20; d0 = done_cnt; early = 1'b0;
      @(negedge clk); bus.run_busy = 1'b1; cfg_buf_a = 32'h100; cfg_buf_b = 32'h200; start = 1'b1;
      @(negedge clk); start = 1'b0;
      // FETCH, WAIT_DESC, CHECK, then 7 cycles of START with run_busy high
      for (int i = 0; i < 10; i++) begin
         if (bus.run_start !== 1'b0) early = 1'b1;
         @(negedge clk);
      end
      n_checks++;
      if (early) $display("FAIL busy_hold: run_start %b while run_busy high want 0", early);
      else n_pass++;
      bus.run_busy = 1'b0;
      #1;
      n_checks++;
      if (bus.run_start !== 1'b1) $display("FAIL busy_fall: got run_start=%b want 1", bus.run_start);
      else n_pass++;
      repeat (4) @(negedge clk);
      cfg_buf_a = 32'hDEAD0000; cfg_buf_b = 32'hBEEF0000; start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (done_cnt == d0 && n < 2000) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      n_checks++;
      if (lg_in_base.size() != 3 || lg_in_base[2] !== ex_in_base[2] || lg_out_base[2] !== ex_out_base[2])
         $display("FAIL busy_start_ignored: got %0d starts want 3 with original bases", lg_in_base.size());
      else n_pass++;
      n_checks++;
      if ({busy, error} !== 2'b00 || done_cnt - d0 != 1 || final_out_base !== 32'h200) $display("FAIL busy_end: got busy=%b err=%b done=%0d fob=%h want 0/0/1/00000200", busy, error, done_cnt - d0, final_out_base);
      else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      int n, d0;
      load_spec_three();
      clear_logs();
      run_lat = 20;
      @(negedge clk); cfg_buf_a = 32'h300; cfg_buf_b = 32'h400; start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (lg_in_base.size() == 0 && n < 50) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, done, error, layer_idx, final_out_base, bus.run_in_base, bus.run_start} !== '0)
         $display("FAIL rst_mid: got busy=%b done=%b err=%b idx=%0d fob=%h inb=%h want all 0",
                  busy, done, error, layer_idx, final_out_base, bus.run_in_base);
      else n_pass++;
      rst = 1'b0; ex_fob = '0;
      d0 = done_cnt;
      repeat (25) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done_cnt != d0) $display("FAIL stray_done: got busy=%b done=%0d want 0/0", busy, done_cnt - d0);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [DIM_W-1:0] ic, oc;
      logic [ADDR_W-1:0] a, b;
      int lat, ab;
      for (int it = 0; it < 20; it++) begin
         for (int l = 0; l < int'(MAX_LAYERS); l++) begin
            if ($urandom_range(0, 9) == 0) ic = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'(1025 + $urandom_range(0, 60000));
            else ic = 16'($urandom_range(1, 1024));
            oc = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            mem[l] = {($urandom_range(0, 2) == 0), oc, ic};
         end
         a = $urandom; b = $urandom;
         lat = $urandom_range(1, 40);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat - 1) : -1;
         model_seq(a, b, (ab >= 0) ? 0 : -1);
         run_seq(a, b, lat, ab);
         n_checks++;
         if (lg_in_base.size() != ex_in_base.size()) $display("FAIL rnd%0d_starts: got %0d want %0d", it, lg_in_base.size(), ex_in_base.size());
         else n_pass++;
         for (int i = 0; i < ex_in_base.size() && i < lg_in_base.size(); i++) begin
            n_checks++;
            if ({lg_in_base[i], lg_out_base[i], lg_in_c[i], lg_out_c[i]} !==
                {ex_in_base[i], ex_out_base[i], ex_in_c[i], ex_out_c[i]})
               $display("FAIL rnd%0d_cfg%0d: got %h/%h/%0d/%0d want %h/%h/%0d/%0d", it, i,
                        lg_in_base[i], lg_out_base[i], lg_in_c[i], lg_out_c[i],
                        ex_in_base[i], ex_out_base[i], ex_in_c[i], ex_out_c[i]);
            else n_pass++;
         end
         n_checks++;
         if ({error, err_code, aborted} !== {(ex_code != 0), 2'(ex_code), ex_ab} || obs_done != 1 || obs_timeout)
            $display("FAIL rnd%0d_status: got err=%b code=%0d ab=%b done=%0d want %0d/%0d/%0d/1",
                     it, error, err_code, aborted, obs_done, ex_code != 0, ex_code, ex_ab);
         else n_pass++;
         n_checks++;
         if (final_out_base !== ex_fob || layer_idx !== IDX_W'(ex_idx) || busy !== 1'b0)
            $display("FAIL rnd%0d_end: got fob=%h idx=%0d busy=%b want %h/%0d/0",
                     it, final_out_base, layer_idx, busy, ex_fob, ex_idx);
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      cfg_buf_a = '0; cfg_buf_b = '0;
      bus.run_busy = 1'b0;
      for (int l = 0; l < int'(MAX_LAYERS); l++) mem[l] = '0;
      test_reset();
      test_three_layers();
      test_bad_desc();
      test_no_last();
      test_watchdog();
      test_abort();
      test_busy_start();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
